// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-channel key debouncer with hold/auto-repeat, timed by a slow tick strobe
module key_debounce #(
  parameter int           N          = 4,
  parameter bit           ACTIVE_LOW = 1'b1,
  parameter int           CNT_W      = 12,
  parameter int           DEB_TICKS  = 78,
  parameter int           HOLD_TICKS = 3906,
  parameter int           REP_TICKS  = 781,
  parameter logic [N-1:0] REPEAT_EN  = '1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         tick,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic [N-1:0] rpt
);

  localparam int MAX_T = (DEB_TICKS > HOLD_TICKS)
                       ? ((DEB_TICKS > REP_TICKS) ? DEB_TICKS : REP_TICKS)
                       : ((HOLD_TICKS > REP_TICKS) ? HOLD_TICKS : REP_TICKS);

  if (MAX_T >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("key_debounce: CNT_W too narrow for the largest tick count");
  end

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, REPEAT, DEB_REL} state_t;

  logic [N-1:0] sync1, sync2, act;

  // Synchronizer idles at the unpressed level so reset never looks like a press.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= {N{ACTIVE_LOW}};
      sync2 <= {N{ACTIVE_LOW}};
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign act = ACTIVE_LOW ? ~sync2 : sync2;

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             lvl_q, prs_q, rel_q, rpt_q;

    // An act change always wins over a coincident tick: the tick is dropped.
    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        st    <= IDLE;
        cnt   <= '0;
        lvl_q <= 1'b0;
        prs_q <= 1'b0;
        rel_q <= 1'b0;
        rpt_q <= 1'b0;
      end else begin
        prs_q <= 1'b0;
        rel_q <= 1'b0;
        rpt_q <= 1'b0;
        case (st)
          IDLE: begin
            if (act[i]) begin
              st  <= DEB_PRESS;
              cnt <= '0;
            end
          end
          DEB_PRESS: begin
            if (!act[i]) begin
              st  <= IDLE;
              cnt <= '0;
            end else if (tick) begin
              if (cnt == DEB_LAST) begin
                st    <= HELD;
                cnt   <= '0;
                lvl_q <= 1'b1;
                prs_q <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          HELD: begin
            if (!act[i]) begin
              st  <= DEB_REL;
              cnt <= '0;
            end else if (tick && REPEAT_EN[i]) begin
              if (cnt == HOLD_LAST) begin
                st    <= REPEAT;
                cnt   <= '0;
                rpt_q <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          REPEAT: begin
            if (!act[i]) begin
              st  <= DEB_REL;
              cnt <= '0;
            end else if (tick) begin
              if (cnt == REP_LAST) begin
                cnt   <= '0;
                rpt_q <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          DEB_REL: begin
            // A bounce back to pressed returns to HELD with a fresh hold timer.
            if (act[i]) begin
              st  <= HELD;
              cnt <= '0;
            end else if (tick) begin
              if (cnt == DEB_LAST) begin
                st    <= IDLE;
                cnt   <= '0;
                lvl_q <= 1'b0;
                rel_q <= 1'b1;
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
          default: begin
            st  <= IDLE;
            cnt <= '0;
          end
        endcase
      end
    end

    assign level[i] = lvl_q;
    assign press[i] = prs_q;
    assign rel[i]   = rel_q;
    assign rpt[i]   = rpt_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - table-driven bench for key_debounce (N=2, DEB=4, HOLD=10, REP=3, tick every 8 clocks)
module tb_key_debounce;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] raw  = 2'b11;
  logic [1:0] lev_a, prs_a, rel_a, rpt_a;
  logic [1:0] lev_b, prs_b, rel_b, rpt_b;

  int nvec  = 0;
  int nfail = 0;
  int ph    = 0;
  int viol  = 0;
  int cp[2], cr[2], cq[2];
  int cpb, crb, cqb;

  always #5 clk = ~clk;

  key_debounce #(.N(2), .ACTIVE_LOW(1'b1), .CNT_W(4), .DEB_TICKS(4), .HOLD_TICKS(10),
                 .REP_TICKS(3), .REPEAT_EN(2'b11)) dut_a (
    .clk(clk), .nrst(nrst), .tick(tick), .raw(raw),
    .level(lev_a), .press(prs_a), .rel(rel_a), .rpt(rpt_a));

  key_debounce #(.N(2), .ACTIVE_LOW(1'b1), .CNT_W(4), .DEB_TICKS(4), .HOLD_TICKS(10),
                 .REP_TICKS(3), .REPEAT_EN(2'b10)) dut_b (
    .clk(clk), .nrst(nrst), .tick(tick), .raw(raw),
    .level(lev_b), .press(prs_b), .rel(rel_b), .rpt(rpt_b));

  typedef struct {
    logic [1:0] raw;
    int         nt;
    int         p0, r0, q0, p1, r1, q1;
    logic [1:0] lv;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < 2; c++) begin
      cp[c] = 0; cr[c] = 0; cq[c] = 0;
    end
    cpb = 0; crb = 0; cqb = 0;
  endtask

  // One clock; tick is high on the 8th clock of every period.
  task automatic clk1();
    tick = (ph == 7);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      cp[c] += int'(prs_a[c]);
      cr[c] += int'(rel_a[c]);
      cq[c] += int'(rpt_a[c]);
      if (prs_a[c] && !lev_a[c]) viol++;
      if (rel_a[c] && lev_a[c]) viol++;
    end
    cpb += int'(prs_b[0]);
    crb += int'(rel_b[0]);
    cqb += int'(rpt_b[0]);
    tick = 1'b0;
    ph = (ph + 1) % 8;
  endtask

  task automatic period();
    repeat (8) clk1();
  endtask

  initial begin
    tbl[0] = '{2'b11, 2, 0, 0, 0, 0, 0, 0, 2'b00};
    for (int k = 0; k < 5; k++) begin
      tbl[1 + 2 * k] = '{2'b10, 2, 0, 0, 0, 0, 0, 0, 2'b00};
      tbl[2 + 2 * k] = '{2'b11, 1, 0, 0, 0, 0, 0, 0, 2'b00};
    end
    tbl[11] = '{2'b10,  4, 1, 0, 0, 0, 0, 0, 2'b01};
    tbl[12] = '{2'b10, 26, 0, 0, 6, 0, 0, 0, 2'b01};
    tbl[13] = '{2'b11,  2, 0, 0, 0, 0, 0, 0, 2'b01};
    tbl[14] = '{2'b10,  9, 0, 0, 0, 0, 0, 0, 2'b01};
    tbl[15] = '{2'b10,  1, 0, 0, 1, 0, 0, 0, 2'b01};
    tbl[16] = '{2'b11,  3, 0, 0, 0, 0, 0, 0, 2'b01};
    tbl[17] = '{2'b11,  1, 0, 1, 0, 0, 0, 0, 2'b00};
    tbl[18] = '{2'b00,  4, 1, 0, 0, 1, 0, 0, 2'b11};
    tbl[19] = '{2'b11,  4, 0, 1, 0, 0, 1, 0, 2'b00};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs_a", int'({lev_a, prs_a, rel_a, rpt_a}), 0);
    chk("reset_outs_b", int'({lev_b, prs_b, rel_b, rpt_b}), 0);
    nrst = 1'b1;
    ph = 0;

    for (int v = 0; v < 20; v++) begin
      clr();
      raw = tbl[v].raw;
      repeat (tbl[v].nt) period();
      chk($sformatf("v%0d_press0", v), cp[0], tbl[v].p0);
      chk($sformatf("v%0d_rel0", v), cr[0], tbl[v].r0);
      chk($sformatf("v%0d_rpt0", v), cq[0], tbl[v].q0);
      chk($sformatf("v%0d_press1", v), cp[1], tbl[v].p1);
      chk($sformatf("v%0d_rel1", v), cr[1], tbl[v].r1);
      chk($sformatf("v%0d_rpt1", v), cq[1], tbl[v].q1);
      chk($sformatf("v%0d_level", v), int'(lev_a), int'(tbl[v].lv));
      chk($sformatf("v%0d_b_press0", v), cpb, tbl[v].p0);
      chk($sformatf("v%0d_b_rel0", v), crb, tbl[v].r0);
      chk($sformatf("v%0d_b_rpt0", v), cqb, 0);
      chk($sformatf("v%0d_b_level0", v), int'(lev_b[0]), int'(tbl[v].lv[0]));
    end

    // act first seen on the tick clock: that tick must not count
    clr();
    repeat (5) clk1();
    raw = 2'b10;
    repeat (3) clk1();
    repeat (3) period();
    chk("coll_no_press_3", cp[0], 0);
    clr();
    period();
    chk("coll_press_4", cp[0], 1);
    chk("coll_b_press_4", cpb, 1);
    chk("coll_level", int'(lev_a[0]), 1);
    clr();
    raw = 2'b11;
    repeat (4) period();
    chk("coll_rel", cr[0], 1);
    chk("coll_rel_level", int'(lev_a[0]), 0);

    // reset while in REPEAT, key still held across it
    clr();
    raw = 2'b10;
    repeat (20) period();
    chk("pre_rst_press", cp[0], 1);
    chk("pre_rst_rpt", cq[0], 3);
    chk("pre_rst_level", int'(lev_a[0]), 1);
    nrst = 1'b0;
    #1;
    chk("rst_async_a", int'({lev_a, prs_a, rel_a, rpt_a}), 0);
    chk("rst_async_b", int'({lev_b, prs_b, rel_b, rpt_b}), 0);
    clr();
    repeat (3) clk1();
    nrst = 1'b1;
    repeat (5) clk1();
    repeat (2) period();
    chk("rst_no_pulse_press", cp[0], 0);
    chk("rst_no_pulse_rel", cr[0], 0);
    chk("rst_no_pulse_rpt", cq[0], 0);
    chk("rst_level_low", int'(lev_a[0]), 0);
    clr();
    period();
    chk("rst_repress", cp[0], 1);
    chk("rst_repress_level", int'(lev_a[0]), 1);

    chk("pulse_level_align", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
